mem_stage: RTL and testbench

- Pipeline MEM stage, directly downstream of the EX stage.
- Consumes the EX/MEM register outputs and drives a request/acknowledge data-memory bus.
- Stalls the upstream pipeline while an access is outstanding.
- Exports branch redirect to IF and registers results into an internal MEM/WB register for the WB stage.

---
 rtl/mem_pkg.sv | 68 ++++++
 rtl/mem_wb_reg.sv | 54 +++++
 rtl/mem_stage.sv | 179 +++++++++++++++++
 tb/tb_mem_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types, funct3 codes, byte-enable constants and
// sub-word helper functions for the MEM stage.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Load sizes/signedness
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    // Store sizes
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Byte enables from access size (funct3[1:0]) and low address bits
    function automatic logic [3:0] size_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   size_be = BE_BYTE0 << a;
            2'b01:   size_be = a[1] ? BE_HALF_HI : BE_HALF_LO;
            default: size_be = BE_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   misaligned = a[0];
            2'b10:   misaligned = (a != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

    // Replicate store data across every lane so the byte enables pick the right one
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   store_data = {4{d[7:0]}};
            2'b01:   store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    // Pull the addressed lane out of the read word and sign/zero-extend it
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> {a, 3'b000};
        case (f3)
            LB:      load_ext = {{24{sh[7]}}, sh[7:0]};
            LBU:     load_ext = {24'h0, sh[7:0]};
            LH:      load_ext = {{16{sh[15]}}, sh[15:0]};
            LHU:     load_ext = {16'h0, sh[15:0]};
            default: load_ext = rd;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register. A stall inserts a bubble
// (writeback disabled) while the remaining fields hold.
module mem_wb_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        rfw_in,
    input  logic [1:0]  sel4_in,
    input  logic [31:0] data_in,
    input  logic [31:0] alu_in,
    output logic        rfw_out,
    output logic [1:0]  sel4_out,
    output logic [31:0] data_out,
    output logic [31:0] alu_out
);
    logic        rfw_q,  rfw_d;
    logic [1:0]  sel4_q, sel4_d;
    logic [31:0] data_q, data_d;
    logic [31:0] alu_q,  alu_d;

    // Next register contents: bubble on stall, otherwise load
    always_comb begin
        rfw_d  = rfw_in;
        sel4_d = sel4_in;
        data_d = data_in;
        alu_d  = alu_in;
        if (stall) begin
            rfw_d  = 1'b0;
            sel4_d = sel4_q;
            data_d = data_q;
            alu_d  = alu_q;
        end
    end

    // Register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rfw_q  <= 1'b0;
            sel4_q <= 2'b00;
            data_q <= 32'h0;
            alu_q  <= 32'h0;
        end else begin
            rfw_q  <= rfw_d;
            sel4_q <= sel4_d;
            data_q <= data_d;
            alu_q  <= alu_d;
        end
    end

    assign rfw_out  = rfw_q;
    assign sel4_out = sel4_q;
    assign data_out = data_q;
    assign alu_out  = alu_q;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage driving a req/ack data-memory bus.
// Stalls upstream while an access is outstanding; optional timeout.
// Define SUBWORD_EN for byte/half accesses with misalignment checking.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_re_in,
    input  logic              mem_we_in,
    input  logic              reg_file_write_in,
    input  logic              branch_in,
    input  logic [1:0]        select_mux_2_in,
    input  logic [1:0]        select_mux_4_in,
    input  logic [2:0]        funct3_in,
    input  logic [31:0]       reg_b_in,
    input  logic [31:0]       alu_in,
    input  logic [31:0]       add_pc_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              stall_out,
    output logic              branch_out,
    output logic [1:0]        select_mux_2_out,
    output logic [31:0]       branch_target_out,
    output logic              bus_error_out,
    output logic              reg_file_write_out,
    output logic [1:0]        select_mux_4_out,
    output logic [31:0]       mem_data_out,
    output logic [31:0]       alu_out
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    state_t            state_q, state_d;
    logic              req_q, req_d, we_q, we_d, err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, data_q, data_d;
    logic [3:0]        be_q, be_d;
    logic [2:0]        f3_q, f3_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              access;
    logic [3:0]        be_new;
    logic [31:0]       wdata_new, rdata_ext;
    logic              misal;

    assign access = mem_re_in | mem_we_in;

`ifdef SUBWORD_EN
    assign be_new    = size_be(funct3_in, alu_in[1:0]);
    assign wdata_new = store_data(funct3_in, reg_b_in);
    assign misal     = misaligned(funct3_in, alu_in[1:0]);
    assign rdata_ext = load_ext(f3_q, addr_q[1:0], dmem_rdata);
`else
    logic unused_f3;
    assign be_new    = BE_WORD;
    assign wdata_new = reg_b_in;
    assign misal     = 1'b0;
    assign rdata_ext = dmem_rdata;
    assign unused_f3 = ^f3_q;
`endif

    // Access FSM next-state: latch request in IDLE, wait for ack/timeout in BUSY
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        f3_d    = f3_q;
        err_d   = err_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    addr_d  = alu_in[ADDR_W-1:0];
                    wdata_d = wdata_new;
                    we_d    = mem_we_in;
                    be_d    = be_new;
                    f3_d    = funct3_in;
                    cnt_d   = '0;
                    data_d  = 32'h0;
                    if (misal) begin
                        // Never reaches the bus; report straight from RESP
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        req_d   = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    data_d  = we_q ? 32'h0 : rdata_ext;
                    req_d   = 1'b0;
                    state_d = RESP;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
                    data_d  = 32'h0;
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and bus registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            be_q    <= BE_NONE;
            f3_q    <= 3'b000;
            err_q   <= 1'b0;
            data_q  <= 32'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            err_q   <= err_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

    assign stall_out     = !reset && ((state_q == BUSY) || (state_q == IDLE && access));
    assign bus_error_out = !reset && (state_q == RESP) && err_q;

    assign branch_out        = branch_in;
    assign select_mux_2_out  = select_mux_2_in;
    assign branch_target_out = add_pc_in;

    mem_wb_reg u_mem_wb (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall_out),
        .rfw_in   (reg_file_write_in),
        .sel4_in  (select_mux_4_in),
        .data_in  ((state_q == RESP) ? data_q : 32'h0),
        .alu_in   (alu_in),
        .rfw_out  (reg_file_write_out),
        .sel4_out (select_mux_4_out),
        .data_out (mem_data_out),
        .alu_out  (alu_out)
    );
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven pass-through vectors, hand-written bus
// sequences, and a writeback scoreboard checked on every MEM/WB write.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_re_in, mem_we_in, reg_file_write_in, branch_in;
    logic [1:0]  select_mux_2_in, select_mux_4_in;
    logic [2:0]  funct3_in;
    logic [31:0] reg_b_in, alu_in, add_pc_in;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stall_out, branch_out, bus_error_out, reg_file_write_out;
    logic [1:0]  select_mux_2_out, select_mux_4_out;
    logic [31:0] branch_target_out, mem_data_out, alu_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .mem_re_in(mem_re_in), .mem_we_in(mem_we_in),
        .reg_file_write_in(reg_file_write_in), .branch_in(branch_in),
        .select_mux_2_in(select_mux_2_in), .select_mux_4_in(select_mux_4_in),
        .funct3_in(funct3_in), .reg_b_in(reg_b_in), .alu_in(alu_in), .add_pc_in(add_pc_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_out(stall_out), .branch_out(branch_out), .select_mux_2_out(select_mux_2_out),
        .branch_target_out(branch_target_out), .bus_error_out(bus_error_out),
        .reg_file_write_out(reg_file_write_out), .select_mux_4_out(select_mux_4_out),
        .mem_data_out(mem_data_out), .alu_out(alu_out)
    );

    typedef struct {
        logic [1:0]  sel4;
        logic [31:0] alu;
        logic [31:0] data;
    } wb_t;
    wb_t sb_q[$];

    typedef struct {
        logic        br;
        logic [1:0]  sel2;
        logic [31:0] pc;
        logic [1:0]  sel4;
        logic [31:0] alu;
        logic        exp_br;
        logic [31:0] exp_tgt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every MEM/WB write must match the oldest expected entry
    always @(posedge clk) begin
        #1;
        if (reg_file_write_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_wb", 32'h1, 32'h0);
            end else begin
                wb_t e;
                e = sb_q.pop_front();
                chk("wb_alu", alu_out, e.alu);
                chk("wb_data", mem_data_out, e.data);
                chk("wb_sel4", {30'h0, select_mux_4_out}, {30'h0, e.sel4});
            end
        end
    end

    task automatic drive_idle();
        mem_re_in = 0; mem_we_in = 0; reg_file_write_in = 0; branch_in = 0;
        select_mux_2_in = 0; select_mux_4_in = 0; funct3_in = 3'b010;
        reg_b_in = 0; alu_in = 0; add_pc_in = 0;
    endtask

    // Issue one access and act as the memory: ack after 'waits' wait states
    task automatic run_access(input logic re, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int waits, input bit ack_en,
                              output int n_stall, output int n_req, output int n_err,
                              output bit stable, output logic [31:0] wd0, output logic [3:0] be0,
                              output logic we0);
        bit done;
        logic [31:0] a0;
        done = 0; n_stall = 0; n_req = 0; n_err = 0; stable = 1;
        a0 = 0; wd0 = 0; be0 = 0; we0 = 0;
        @(negedge clk);
        mem_re_in = re; mem_we_in = we; funct3_in = f3; alu_in = addr; reg_b_in = wdata;
        reg_file_write_in = 1; select_mux_4_in = 2'b01;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (stall_out) n_stall++;
            if (dmem_req) begin
                n_req++;
                if (n_req == 1) begin
                    a0 = dmem_addr; wd0 = dmem_wdata; be0 = dmem_be; we0 = dmem_we;
                end else if (dmem_addr != a0 || dmem_wdata != wd0 || dmem_be != be0 || dmem_we != we0) begin
                    stable = 0;
                end
                dmem_ack   = ack_en && (n_req == waits + 1);
                dmem_rdata = dmem_ack ? rdata : 32'hBAD0BAD0;
            end else begin
                dmem_ack = 0;
            end
            if (bus_error_out) n_err++;
            if (n_stall > 0 && !stall_out) begin
                @(posedge clk); #1;
                drive_idle();
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            chk("access_timeout", 32'h0, 32'h1);
            drive_idle();
        end
    endtask

    initial begin
        vec_t vecs[4];
        int ns, nr, ne;
        bit st;
        logic [31:0] wd0;
        logic [3:0] be0;
        logic we0;

        vecs[0] = '{br:1, sel2:2'b01, pc:32'h80,       sel4:2'b00, alu:32'h1111_0000, exp_br:1, exp_tgt:32'h80};
        vecs[1] = '{br:0, sel2:2'b10, pc:32'hFFFF_FFFC, sel4:2'b10, alu:32'hA5A5_A5A5, exp_br:0, exp_tgt:32'hFFFF_FFFC};
        vecs[2] = '{br:1, sel2:2'b11, pc:32'h0,         sel4:2'b11, alu:32'h0,         exp_br:1, exp_tgt:32'h0};
        vecs[3] = '{br:0, sel2:2'b00, pc:32'h1234_5678, sel4:2'b01, alu:32'hFFFF_FFFF, exp_br:0, exp_tgt:32'h1234_5678};

        drive_idle();
        dmem_ack = 0; dmem_rdata = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_we", {31'h0, dmem_we}, 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_be", {28'h0, dmem_be}, 32'h0);
        chk("rst_stall", {31'h0, stall_out}, 32'h0);
        chk("rst_err", {31'h0, bus_error_out}, 32'h0);
        chk("rst_rfw", {31'h0, reg_file_write_out}, 32'h0);
        chk("rst_data", mem_data_out, 32'h0);
        chk("rst_alu", alu_out, 32'h0);
        @(negedge clk);
        reset = 0;

        // Non-memory pass-through vectors: 1-cycle latency, data 0
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            branch_in = vecs[i].br; select_mux_2_in = vecs[i].sel2; add_pc_in = vecs[i].pc;
            reg_file_write_in = 1; select_mux_4_in = vecs[i].sel4; alu_in = vecs[i].alu;
            sb_q.push_back('{sel4:vecs[i].sel4, alu:vecs[i].alu, data:32'h0});
            #1;
            chk("branch_out", {31'h0, branch_out}, {31'h0, vecs[i].exp_br});
            chk("branch_target", branch_target_out, vecs[i].exp_tgt);
            chk("sel2_out", {30'h0, select_mux_2_out}, {30'h0, vecs[i].sel2});
            chk("nomem_stall", {31'h0, stall_out}, 32'h0);
        end
        @(negedge clk);
        drive_idle();

        // Load, zero-wait ack
        sb_q.push_back('{sel4:2'b01, alu:32'h100, data:32'hDEAD_BEEF});
        run_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1, ns, nr, ne, st, wd0, be0, we0);
        chk("ld_stall_cycles", ns, 2);
        chk("ld_req_cycles", nr, 1);
        chk("ld_we", {31'h0, we0}, 32'h0);
        chk("ld_be", {28'h0, be0}, 32'hF);
        chk("ld_err", ne, 0);

        // Store, 3 wait states
        sb_q.push_back('{sel4:2'b01, alu:32'h40, data:32'h0});
        run_access(0, 1, 3'b010, 32'h40, 32'h1234_5678, 32'h5555_AAAA, 3, 1, ns, nr, ne, st, wd0, be0, we0);
        chk("st_req_cycles", nr, 4);
        chk("st_stall_cycles", ns, 5);
        chk("st_we", {31'h0, we0}, 32'h1);
        chk("st_wdata", wd0, 32'h1234_5678);
        chk("st_stable", {31'h0, st}, 32'h1);

        // No ack: timeout after 4 BUSY cycles
        sb_q.push_back('{sel4:2'b01, alu:32'h300, data:32'h0});
        run_access(1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 0, 0, ns, nr, ne, st, wd0, be0, we0);
        chk("to_req_cycles", nr, 4);
        chk("to_err_pulse", ne, 1);
        chk("to_stall_cycles", ns, 5);

        // Read and write together behaves as a write: no read data
        sb_q.push_back('{sel4:2'b01, alu:32'h44, data:32'h0});
        run_access(1, 1, 3'b010, 32'h44, 32'hCAFE_F00D, 32'h7777_7777, 1, 1, ns, nr, ne, st, wd0, be0, we0);
        chk("rw_we", {31'h0, we0}, 32'h1);
        chk("rw_req_cycles", nr, 2);

        // Reset in the second BUSY cycle, then a late ack
        @(negedge clk);
        mem_re_in = 1; alu_in = 32'h200;
        @(negedge clk);
        chk("rst_mid_busy1", {31'h0, dmem_req}, 32'h1);
        @(negedge clk);
        chk("rst_mid_busy2", {31'h0, dmem_req}, 32'h1);
        reset = 1; mem_re_in = 0;
        @(posedge clk); #1;
        chk("rst_mid_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_mid_stall", {31'h0, stall_out}, 32'h0);
        @(negedge clk);
        reset = 0; dmem_ack = 1; dmem_rdata = 32'h9999_9999;
        @(posedge clk); #1;
        chk("late_ack_req", {31'h0, dmem_req}, 32'h0);
        chk("late_ack_stall", {31'h0, stall_out}, 32'h0);
        chk("late_ack_err", {31'h0, bus_error_out}, 32'h0);
        @(negedge clk);
        dmem_ack = 0;

        // Recovery: a normal load with one wait state
        sb_q.push_back('{sel4:2'b01, alu:32'h204, data:32'h0BAD_F00D});
        run_access(1, 0, 3'b010, 32'h204, 32'h0, 32'h0BAD_F00D, 1, 1, ns, nr, ne, st, wd0, be0, we0);
        chk("rec_stall_cycles", ns, 3);

`ifdef SUBWORD_EN
        sb_q.push_back('{sel4:2'b01, alu:32'h103, data:32'hFFFF_FF80});
        run_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 1, ns, nr, ne, st, wd0, be0, we0);
        chk("lb_be", {28'h0, be0}, 32'h8);
        chk("lb_req_cycles", nr, 1);

        sb_q.push_back('{sel4:2'b01, alu:32'h101, data:32'h0});
        run_access(1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 1, ns, nr, ne, st, wd0, be0, we0);
        chk("mis_req_cycles", nr, 0);
        chk("mis_err_pulse", ne, 1);
`endif

        repeat (3) @(posedge clk);
        #2;
        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
